// File: rtl/bus_pkg.sv
// Shared constants and types for the registered bus multiplexer.
// Source index map follows the processor's datapath ordering (R0..R31, G, DIN, Sin, Cos).
package bus_pkg;

  localparam int NSRC_DEFAULT  = 36;
  localparam int WIDTH_DEFAULT = 32;

  localparam int SRC_R0  = 0;
  localparam int SRC_R1  = 1;
  localparam int SRC_R2  = 2;
  localparam int SRC_R3  = 3;
  localparam int SRC_R4  = 4;
  localparam int SRC_R5  = 5;
  localparam int SRC_R6  = 6;
  localparam int SRC_R7  = 7;
  localparam int SRC_R8  = 8;
  localparam int SRC_R9  = 9;
  localparam int SRC_R10 = 10;
  localparam int SRC_R11 = 11;
  localparam int SRC_R12 = 12;
  localparam int SRC_R13 = 13;
  localparam int SRC_R14 = 14;
  localparam int SRC_R15 = 15;
  localparam int SRC_R16 = 16;
  localparam int SRC_R17 = 17;
  localparam int SRC_R18 = 18;
  localparam int SRC_R19 = 19;
  localparam int SRC_R20 = 20;
  localparam int SRC_R21 = 21;
  localparam int SRC_R22 = 22;
  localparam int SRC_R23 = 23;
  localparam int SRC_R24 = 24;
  localparam int SRC_R25 = 25;
  localparam int SRC_R26 = 26;
  localparam int SRC_R27 = 27;
  localparam int SRC_R28 = 28;
  localparam int SRC_R29 = 29;
  localparam int SRC_R30 = 30;
  localparam int SRC_R31 = 31;
  localparam int SRC_G   = 32;
  localparam int SRC_DIN = 33;
  localparam int SRC_SIN = 34;
  localparam int SRC_COS = 35;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ONE,
    SEL_MULTI
  } sel_class_t;

endpackage

// File: rtl/bus_sel_decode.sv
// Combinational select classifier: NONE / ONE / MULTI plus lowest set index.
// No state; the parent registers everything it derives from these outputs.
module bus_sel_decode
  import bus_pkg::*;
#(
  parameter int NSRC = NSRC_DEFAULT
) (
  input  logic [NSRC-1:0]         sel,
  output sel_class_t              sel_class,
  output logic [$clog2(NSRC)-1:0] low_idx
);

  localparam int IDX_W = $clog2(NSRC);

  logic seen;
  logic multi;

  // Scan upward so the first hit is the lowest index; a second hit marks MULTI.
  always_comb begin
    seen    = 1'b0;
    multi   = 1'b0;
    low_idx = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel[i]) begin
        if (seen) begin
          multi = 1'b1;
        end else begin
          low_idx = IDX_W'(i);
        end
        seen = 1'b1;
      end
    end
  end

  always_comb begin
    sel_class = SEL_NONE;
    if (multi) begin
      sel_class = SEL_MULTI;
    end else if (seen) begin
      sel_class = SEL_ONE;
    end
  end

endmodule

// File: rtl/bus_mux_pipe.sv
// Registered one-hot bus multiplexer with source index, valid flag and sticky collision count.
// Define BUS_PRIORITY_EN to resolve multi-selects to the lowest set source instead of zero.
module bus_mux_pipe
  import bus_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter int NSRC      = NSRC_DEFAULT,
  parameter int HOLD_IDLE = 1,
  parameter int CNT_W     = 16
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [NSRC*WIDTH-1:0]   src_data,
  input  logic [NSRC-1:0]         sel,
  input  logic                    clr_err,
  output logic [WIDTH-1:0]        BUS,
  output logic                    bus_valid,
  output logic [$clog2(NSRC)-1:0] bus_src,
  output logic                    collision,
  output logic [CNT_W-1:0]        coll_count
);

  localparam int IDX_W = $clog2(NSRC);

  sel_class_t       sel_class;
  logic [IDX_W-1:0] low_idx;
  logic [WIDTH-1:0] sel_dat;

  logic [WIDTH-1:0] bus_q, bus_d;
  logic             vld_q, vld_d;
  logic [IDX_W-1:0] src_q, src_d;
  logic             coll_q, coll_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  bus_sel_decode #(
    .NSRC(NSRC)
  ) u_dec (
    .sel      (sel),
    .sel_class(sel_class),
    .low_idx  (low_idx)
  );

  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (IDX_W'(i) == low_idx) begin
        sel_dat = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    bus_d  = bus_q;
    vld_d  = 1'b0;
    src_d  = src_q;
    coll_d = coll_q;
    cnt_d  = cnt_q;
    if (clr_err) begin
      coll_d = 1'b0;
      cnt_d  = '0;
    end
    case (sel_class)
      SEL_ONE: begin
        bus_d = sel_dat;
        src_d = low_idx;
        vld_d = 1'b1;
      end
      SEL_MULTI: begin
`ifdef BUS_PRIORITY_EN
        bus_d = sel_dat;
        src_d = low_idx;
        vld_d = 1'b1;
`else
        bus_d = '0;
`endif
        coll_d = 1'b1;
        // A collision in the clearing cycle counts as the first event after the clear.
        if (clr_err) begin
          cnt_d = CNT_W'(1);
        end else if (!(&cnt_q)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (HOLD_IDLE == 0) begin
          bus_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bus_q  <= '0;
      vld_q  <= 1'b0;
      src_q  <= '0;
      coll_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      bus_q  <= bus_d;
      vld_q  <= vld_d;
      src_q  <= src_d;
      coll_q <= coll_d;
      cnt_q  <= cnt_d;
    end
  end

  assign BUS        = bus_q;
  assign bus_valid  = vld_q;
  assign bus_src    = src_q;
  assign collision  = coll_q;
  assign coll_count = cnt_q;

endmodule

// File: doc/bus_mux_pipe.md
Name: bus_mux_pipe

Overview:
- Parametrised, registered successor to the processor's one-hot bus multiplexer; drives the shared datapath BUS from NSRC sources (R0..R31, G, DIN, Sin, Cos by default).
- Adds a one-cycle output register, an encoded source index, a valid flag, idle-hold mode, and sticky multi-select (collision) detection with a saturating event counter.
- Sits between the register file, CORDIC, and DIN sources and the bus consumers.

Parameters:
- WIDTH, 32, bus/source data width in bits.
- NSRC, 36, number of bus sources; must be >= 2.
- HOLD_IDLE, 1, 1: hold the last BUS value when no source is selected; 0: drive zero.
- CNT_W, 16, width of the collision counter.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- src_data  in  NSRC*WIDTH  packed source data; source i occupies bits [i*WIDTH +: WIDTH].
- sel  in  NSRC  one-hot source select; sel[i] selects source i.
- clr_err  in  1  synchronous clear of collision and coll_count.
- BUS  out  WIDTH  registered bus value.
- bus_valid  out  1  BUS was driven by exactly one source in the previous cycle.
- bus_src  out  $clog2(NSRC)  encoded index of the driving source.
- collision  out  1  sticky flag: more than one sel bit was seen.
- coll_count  out  CNT_W  saturating count of collision cycles.

Behaviour:
- Reset, asynchronous and active-high: BUS=0, bus_valid=0, bus_src=0, collision=0, coll_count=0. Reset asserted mid-operation clears all state immediately. The first capture occurs on the first rising edge after deassertion.
- Each cycle, sel is classified combinationally as NONE (popcount 0), ONE (popcount 1), or MULTI (popcount >= 2). Results register on the next rising edge, giving a latency of 1 cycle from sel/src_data to BUS.
- ONE:
  - BUS <= src_data of index i.
  - bus_src <= i.
  - bus_valid <= 1.
- NONE:
  - bus_valid <= 0.
  - bus_src holds its value.
  - BUS holds its value if HOLD_IDLE=1; otherwise BUS <= 0.
- MULTI, without the optional feature:
  - BUS <= 0, bus_valid <= 0, bus_src holds its value.
  - collision <= 1.
  - coll_count increments by 1 and saturates at all-ones (no wrap).
- clr_err=1: collision <= 0 and coll_count <= 0. If a MULTI occurs in the same cycle, the collision wins: collision <= 1 and coll_count <= 1.
- src_data changing while sel is stable: the new data appears on BUS after 1 cycle. There is no combinational path from any input to any output.
- Data bits are never shifted, extended, or truncated; all sources are exactly WIDTH bits.

Optional Feature:
- Macro: BUS_PRIORITY_EN.
- Defined: a MULTI select resolves to the lowest set index.
  - BUS <= that source, bus_src <= that index, bus_valid <= 1.
  - collision and coll_count still update as for MULTI.
- Undefined: MULTI behaves as described in Behaviour (BUS=0, bus_valid=0).

Decomposition:
- Package bus_pkg:
  - Source index constants: SRC_R0..SRC_R31 = 0..31, SRC_G = 32, SRC_DIN = 33, SRC_SIN = 34, SRC_COS = 35.
  - NSRC_DEFAULT = 36 and WIDTH_DEFAULT = 32.
  - Enum sel_class_t {SEL_NONE, SEL_ONE, SEL_MULTI}.
- Sub-module bus_sel_decode: purely combinational. Takes sel and outputs sel_class_t plus the lowest set index. bus_mux_pipe instantiates it once and holds all registers.

Test Plan:
- Reset check: assert Reset asynchronously mid-clock with all sources = 32'hA5A5_0000+i -> all outputs read 0 immediately; after release, sel=1<<SRC_DIN with DIN=32'h1234_5678 -> next cycle BUS=32'h1234_5678, bus_src=33, bus_valid=1.
- Walking one-hot: source i = 32'hC0DE_0000+i, step sel through all 36 bits -> each cycle after: BUS=32'hC0DE_0000+i, bus_src=i, bus_valid=1, collision stays 0.
- Idle select: select R5=32'hDEAD_BEEF, then sel=0 -> with HOLD_IDLE=1, BUS stays 32'hDEAD_BEEF and bus_valid=0; with HOLD_IDLE=0, BUS=0.
- Collision: sel has bits 3 and 34 set -> BUS=0, bus_valid=0, collision=1, coll_count=1 (with BUS_PRIORITY_EN: BUS=R3, bus_src=3, bus_valid=1).
- Saturation and clear: CNT_W=4, 20 consecutive MULTI cycles -> coll_count=4'hF; clr_err alone -> 0; clr_err with MULTI in the same cycle -> collision=1, coll_count=1.
- Data tracking: sel fixed at SRC_COS, Cos changes every cycle -> BUS equals the previous cycle's Cos value on every cycle.
